imem_refill_responder: RTL and testbench
========================================

Name: imem_refill_responder

Overview:
- Memory-side responder for the instruction-cache line refill protocol.
- The fetch-stage I-cache raises reqI_mem with a line address on a miss. This block waits a fixed memory latency, then returns one full cache line, and holds it until the cache acknowledges the fill.
- It models main memory for the instruction side and sits between the fetch stage and the memory/boot-loader path.
- A separate load port preloads program lines before or between requests.

Parameters:
- LINE_WIDTH, 128, bits per I-cache line (returned in one beat).
- LINE_ADDR_WIDTH, 28, width of the line address (the I-cache tag/line identifier).
- INDEX_WIDTH, 12, low line-address bits used to index the backing store (4096 lines).
- LATENCY, 5, cycles from request acceptance to mem_data_rdy assertion; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- reqI_mem  input  1  refill request from the I-cache, level-held.
- reqAddrI_mem  input  LINE_ADDR_WIDTH  line address of the request.
- data_filled_ack  input  1  I-cache has written the returned line.
- load_en  input  1  preload write strobe.
- load_addr  input  LINE_ADDR_WIDTH  preload line address.
- load_data  input  LINE_WIDTH  preload line data.
- instr_from_mem  output  LINE_WIDTH  returned line; valid while mem_data_rdy=1.
- mem_data_rdy  output  1  returned line valid.
- busy  output  1  request accepted and not yet acknowledged.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, counter=0.
  - mem_data_rdy=0, instr_from_mem=0, captured address=0, busy=0.
  - The backing store is NOT cleared; contents survive reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - busy=0, mem_data_rdy=0.
  - If reqI_mem=1 at a posedge: capture reqAddrI_mem, load counter=LATENCY-1, go to WAIT.
- WAIT:
  - busy=1. Counter decrements each cycle.
  - When counter==0 at a posedge: register store[captured_addr[INDEX_WIDTH-1:0]] into instr_from_mem, set mem_data_rdy=1, go to RESP.
  - Timing: request sampled at edge N gives mem_data_rdy=1 after edge N+LATENCY. With LATENCY=1, WAIT lasts one cycle.
  - reqI_mem and reqAddrI_mem changes during WAIT/RESP are ignored; the address is the one captured in IDLE.
- RESP:
  - busy=1. mem_data_rdy=1 and instr_from_mem are held stable for every cycle until the acknowledge.
  - data_filled_ack=1 at a posedge: go to IDLE, clear mem_data_rdy. instr_from_mem keeps its last value.
- Back-to-back requests:
  - Leaving RESP always passes through at least one IDLE cycle.
  - A reqI_mem still high in that IDLE cycle is accepted as a new request. The initiator must drop reqI_mem in the cycle it acks if it wants no further service.
- data_filled_ack outside RESP: ignored; no state change.
- Address range: addresses wrap modulo 2^INDEX_WIDTH lines; upper address bits are ignored. No error is signalled.
- Preload port:
  - load_en=1 at a posedge writes load_data to store[load_addr[INDEX_WIDTH-1:0]]. Accepted in any state.
  - A load to the pending line during WAIT, including in the same cycle as the counter==0 read, is visible in the response. Read-after-write priority: the same-edge write data is forwarded.
  - A load during RESP does not alter the held instr_from_mem.
- Reset asserted mid-WAIT or mid-RESP: immediate return to IDLE with outputs at reset values. No response is ever delivered for the aborted request.
- Counter width: 4 bits, sufficient for LATENCY≤15.

Test Plan:
- Basic refill: preload line 0x0000100 = 0x0123_4567_89AB_CDEF_0011_2233_4455_6677; raise req with addr 0x0000100 at edge 0 -> mem_data_rdy=1 with that data after edge 5; held until ack; deasserts one edge after ack.
- Held response: no ack for 10 cycles -> mem_data_rdy stays 1 and data is unchanged. Toggle reqAddrI_mem to 0x0000200 meanwhile -> no effect on returned data.
- Back-to-back: req held high through ack -> one IDLE cycle with mem_data_rdy=0, then a second response 5 cycles later. Drop req at ack -> busy=0 stays.
- Wrap and forwarding: preload 0x1000005 = A; request 0x0000005 -> returns A. Request 0x0000005 and write B to the same line on the final WAIT edge -> returns B.
- Reset mid-operation: assert reset=0 two cycles into WAIT -> mem_data_rdy=0, busy=0 immediately. After release, preloaded contents are still readable.
- Spurious ack: pulse data_filled_ack in IDLE and in WAIT -> no state change; response timing is unaffected.

Source files
------------

// File: rtl/imem_refill_responder.sv
// rtl/imem_refill_responder.sv - instruction-side memory responder for I-cache line refills
module imem_refill_responder #(
    parameter int LINE_WIDTH      = 128,
    parameter int LINE_ADDR_WIDTH = 28,
    parameter int INDEX_WIDTH     = 12,
    parameter int LATENCY         = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       reqI_mem,
    input  logic [LINE_ADDR_WIDTH-1:0] reqAddrI_mem,
    input  logic                       data_filled_ack,
    input  logic                       load_en,
    input  logic [LINE_ADDR_WIDTH-1:0] load_addr,
    input  logic [LINE_WIDTH-1:0]      load_data,
    output logic [LINE_WIDTH-1:0]      instr_from_mem,
    output logic                       mem_data_rdy,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                       state, state_nxt;
    logic [3:0]                   counter, counter_nxt;
    logic [LINE_ADDR_WIDTH-1:0]   cap_addr;
    logic                         capture;
    logic                         fill;
    logic [LINE_WIDTH-1:0]        store [0:(1 << INDEX_WIDTH) - 1];
    logic [INDEX_WIDTH-1:0]       rd_idx;
    logic [INDEX_WIDTH-1:0]       ld_idx;
    logic [LINE_WIDTH-1:0]        rd_data;

    assign rd_idx = cap_addr[INDEX_WIDTH-1:0];
    assign ld_idx = load_addr[INDEX_WIDTH-1:0];

    // A preload landing on the pending line in the fill cycle must win over the old contents.
    assign rd_data = (load_en && (ld_idx == rd_idx)) ? load_data : store[rd_idx];

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        capture     = 1'b0;
        fill        = 1'b0;
        case (state)
            IDLE: begin
                if (reqI_mem) begin
                    capture     = 1'b1;
                    counter_nxt = LAT_M1;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (counter == 4'd0) begin
                    fill      = 1'b1;
                    state_nxt = RESP;
                end else begin
                    counter_nxt = counter - 4'd1;
                end
            end
            RESP: begin
                if (data_filled_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            counter        <= 4'd0;
            cap_addr       <= '0;
            instr_from_mem <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            if (capture) begin
                cap_addr <= reqAddrI_mem;
            end
            if (fill) begin
                instr_from_mem <= rd_data;
            end
        end
    end

    // Backing store has no reset so preloaded program lines survive a reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            store[ld_idx] <= load_data;
        end
    end

    assign mem_data_rdy = (state == RESP);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_imem_refill_responder.sv
// tb/tb_imem_refill_responder.sv - directed self-checking bench for imem_refill_responder
module tb_imem_refill_responder;

    logic         clk;
    logic         reset;
    logic         reqI_mem;
    logic [27:0]  reqAddrI_mem;
    logic         data_filled_ack;
    logic         load_en;
    logic [27:0]  load_addr;
    logic [127:0] load_data;
    logic [127:0] instr_from_mem;
    logic         mem_data_rdy;
    logic         busy;

    int vectors;
    int miscompares;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    localparam logic [127:0] DA = 128'hAAAA_0000_AAAA_1111_AAAA_2222_AAAA_3333;
    localparam logic [127:0] DB = 128'hBBBB_4444_BBBB_5555_BBBB_6666_BBBB_7777;
    localparam logic [127:0] DC = 128'hCCCC_8888_CCCC_9999_CCCC_AAAA_CCCC_BBBB;

    imem_refill_responder dut (
        .clk             (clk),
        .reset           (reset),
        .reqI_mem        (reqI_mem),
        .reqAddrI_mem    (reqAddrI_mem),
        .data_filled_ack (data_filled_ack),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .instr_from_mem  (instr_from_mem),
        .mem_data_rdy    (mem_data_rdy),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [27:0] a, input logic [127:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        reqI_mem = 1'b0; reqAddrI_mem = '0; data_filled_ack = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick();
        vectors++;
        if (mem_data_rdy !== 1'b0 || busy !== 1'b0 || instr_from_mem !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b busy=%b data=%h, want 0 0 0", mem_data_rdy, busy, instr_from_mem);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_refill();
        preload(28'h0000100, D1);
        preload(28'h0000200, D2);
        reqAddrI_mem = 28'h0000100; reqI_mem = 1'b1;
        tick();
        reqI_mem = 1'b0;
        vectors++;
        if (busy !== 1'b1 || mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_accept: busy=%b rdy=%b, want 1 0", busy, mem_data_rdy);
        end
        repeat (4) tick();
        vectors++;
        if (mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early: rdy=%b after edge 4, want 0", mem_data_rdy);
        end
        tick();
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== D1) begin
            miscompares++;
            $display("FAIL basic_resp: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, D1);
        end
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
        vectors++;
        if (mem_data_rdy !== 1'b0 || busy !== 1'b0 || instr_from_mem !== D1) begin
            miscompares++;
            $display("FAIL basic_ack: rdy=%b busy=%b data=%h, want 0 0 %h", mem_data_rdy, busy, instr_from_mem, D1);
        end
    endtask

    task automatic test_held_response();
        reqAddrI_mem = 28'h0000100; reqI_mem = 1'b1;
        tick();
        reqI_mem = 1'b0;
        reqAddrI_mem = 28'h0000200;
        repeat (5) tick();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (mem_data_rdy !== 1'b1 || busy !== 1'b1 || instr_from_mem !== D1) begin
                miscompares++;
                $display("FAIL held_resp[%0d]: rdy=%b busy=%b data=%h, want 1 1 %h", i, mem_data_rdy, busy, instr_from_mem, D1);
            end
            reqAddrI_mem = (i % 2 == 0) ? 28'h0000100 : 28'h0000200;
            tick();
        end
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
        vectors++;
        if (mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL held_ack: rdy=%b, want 0", mem_data_rdy);
        end
    endtask

    task automatic test_back_to_back();
        reqAddrI_mem = 28'h0000100; reqI_mem = 1'b1;
        tick();
        repeat (5) tick();
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== D1) begin
            miscompares++;
            $display("FAIL b2b_first: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, D1);
        end
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
        vectors++;
        if (mem_data_rdy !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_gap: rdy=%b busy=%b, want 0 0", mem_data_rdy, busy);
        end
        reqAddrI_mem = 28'h0000200;
        tick();
        vectors++;
        if (busy !== 1'b1 || mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_reaccept: busy=%b rdy=%b, want 1 0", busy, mem_data_rdy);
        end
        repeat (4) tick();
        vectors++;
        if (mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_early: rdy=%b, want 0", mem_data_rdy);
        end
        tick();
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== D2) begin
            miscompares++;
            $display("FAIL b2b_second: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, D2);
        end
        data_filled_ack = 1'b1; reqI_mem = 1'b0;
        tick();
        data_filled_ack = 1'b0;
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0 || mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drop: busy=%b rdy=%b, want 0 0", busy, mem_data_rdy);
        end
    endtask

    task automatic test_wrap_forward();
        preload(28'h1000005, DA);
        reqAddrI_mem = 28'h0000005; reqI_mem = 1'b1;
        tick();
        reqI_mem = 1'b0;
        repeat (5) tick();
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== DA) begin
            miscompares++;
            $display("FAIL wrap_read: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, DA);
        end
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
        reqAddrI_mem = 28'h0000005; reqI_mem = 1'b1;
        tick();
        reqI_mem = 1'b0;
        repeat (4) tick();
        load_en = 1'b1; load_addr = 28'h0000005; load_data = DB;
        tick();
        load_en = 1'b0;
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== DB) begin
            miscompares++;
            $display("FAIL forward_same_edge: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, DB);
        end
        preload(28'h0000005, DC);
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== DB) begin
            miscompares++;
            $display("FAIL load_in_resp: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, DB);
        end
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        reqAddrI_mem = 28'h0000100; reqI_mem = 1'b1;
        tick();
        reqI_mem = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (mem_data_rdy !== 1'b0 || busy !== 1'b0 || instr_from_mem !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_mid: rdy=%b busy=%b data=%h, want 0 0 0", mem_data_rdy, busy, instr_from_mem);
        end
        tick();
        reset = 1'b1;
        repeat (8) tick();
        vectors++;
        if (mem_data_rdy !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_resp: rdy=%b busy=%b, want 0 0", mem_data_rdy, busy);
        end
        reqAddrI_mem = 28'h0000100; reqI_mem = 1'b1;
        tick();
        reqI_mem = 1'b0;
        repeat (5) tick();
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== D1) begin
            miscompares++;
            $display("FAIL reset_store_kept: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, D1);
        end
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
    endtask

    task automatic test_spurious_ack();
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
        vectors++;
        if (busy !== 1'b0 || mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_in_idle: busy=%b rdy=%b, want 0 0", busy, mem_data_rdy);
        end
        reqAddrI_mem = 28'h0000200; reqI_mem = 1'b1;
        tick();
        reqI_mem = 1'b0;
        tick();
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
        vectors++;
        if (busy !== 1'b1 || mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_in_wait: busy=%b rdy=%b, want 1 0", busy, mem_data_rdy);
        end
        tick(); tick();
        vectors++;
        if (mem_data_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_wait_early: rdy=%b, want 0", mem_data_rdy);
        end
        tick();
        vectors++;
        if (mem_data_rdy !== 1'b1 || instr_from_mem !== D2) begin
            miscompares++;
            $display("FAIL ack_wait_timing: rdy=%b data=%h, want 1 %h", mem_data_rdy, instr_from_mem, D2);
        end
        data_filled_ack = 1'b1;
        tick();
        data_filled_ack = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_refill();
        test_held_response();
        test_back_to_back();
        test_wrap_forward();
        test_reset_mid();
        test_spurious_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
